// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage between Ex and WB.
// Issues one data-memory transaction per load/store over a req/ack bus,
// formats store lanes/byte-enables and load data, and stalls upstream
// until the access completes. Results land in the Mem/WB registers.
//
// Ports:
//   clk, reset (async, active-low)  clock and reset
//   MemREGclear                     synchronous flush of Mem/WB registers
//   REGA*                           Ex/Mem pipeline register inputs
//   MemREGstall                     hold Ex and upstream stages
//   dmem_*                          data-memory req/ack bus (req registered)
//   REGM*                           Mem/WB pipeline registers
//
// Optional build macro MISALIGN_TRAP_EN: adds output REGMmisalign and turns
// misaligned halfword/word accesses into a no-bus trap writeback.
module mem_stage_lsu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemREGclear,
    input  logic [4:0]       REGArd,
    input  logic [WIDTH-1:0] REGAaluresult,
    input  logic [WIDTH-1:0] REGAreg2data,
    input  logic [1:0]       REGAmem2reg,
    input  logic [2:0]       REGAllcntl,
    input  logic [2:0]       REGAslcntl,
    input  logic             REGAregwrite,
    input  logic             REGAiord,
    input  logic             REGAwenable,
    output logic             MemREGstall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic             REGMmisalign,
`endif
    output logic [4:0]       REGMrd,
    output logic [WIDTH-1:0] REGMresult,
    output logic             REGMregwrite,
    output logic [1:0]       REGMmem2reg
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic             kill;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] lat_addr;
    logic [2:0]       lat_ll;
    logic [4:0]       lat_rd;
    logic             lat_rw;
    logic [1:0]       lat_m2r;
    logic             lat_load;

    logic             memop_c;
    logic             trap_c;
    logic             start_c;
    logic [WIDTH-1:0] wdata_c;
    logic [3:0]       be_c;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [WIDTH-1:0] load_fmt;
    logic [4:0]       n_rd;
    logic [WIDTH-1:0] n_res;
    logic             n_rw;
    logic [1:0]       n_m2r;

    // A request with both iord and wenable set is handled as a store.
    assign memop_c = REGAiord | REGAwenable;

`ifdef MISALIGN_TRAP_EN
    logic misalign_c;
    logic n_mis;

    // Natural-alignment check by access size.
    always_comb begin
        misalign_c = 1'b0;
        if (REGAwenable) begin
            case (REGAslcntl)
                3'b000:  misalign_c = 1'b0;
                3'b001:  misalign_c = REGAaluresult[0];
                default: misalign_c = |REGAaluresult[1:0];
            endcase
        end else begin
            case (REGAllcntl)
                3'b000, 3'b100: misalign_c = 1'b0;
                3'b001, 3'b101: misalign_c = REGAaluresult[0];
                default:        misalign_c = |REGAaluresult[1:0];
            endcase
        end
    end
    assign trap_c = memop_c & misalign_c;
`else
    assign trap_c = 1'b0;
`endif

    assign start_c = memop_c & ~trap_c;

    // Gated by reset so the stall drops the instant reset asserts.
    assign MemREGstall = reset & (((state == IDLE) & start_c) | (state == BUSY));

    // Store lane replication and byte enables; loads use all lanes.
    always_comb begin
        wdata_c = REGAreg2data;
        be_c    = 4'b1111;
        if (REGAwenable) begin
            case (REGAslcntl)
                3'b000: begin
                    wdata_c = {4{REGAreg2data[7:0]}};
                    be_c    = 4'b0001 << REGAaluresult[1:0];
                end
                3'b001: begin
                    wdata_c = {2{REGAreg2data[15:0]}};
                    be_c    = 4'b0011 << {REGAaluresult[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction and sign/zero extension from latched controls.
    always_comb begin
        lane_byte = dmem_rdata[{lat_addr[1:0], 3'b000} +: 8];
        lane_half = lat_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_ll)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_fmt = {24'b0, lane_byte};
            3'b101:  load_fmt = {16'b0, lane_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // Next Mem/WB contents; bubble unless an op completes and no flush.
    always_comb begin
        n_rd  = '0;
        n_res = '0;
        n_rw  = 1'b0;
        n_m2r = '0;
`ifdef MISALIGN_TRAP_EN
        n_mis = 1'b0;
`endif
        if (!MemREGclear) begin
            if (state == IDLE && !start_c) begin
                n_rd  = REGArd;
                n_res = REGAaluresult;
                n_rw  = REGAregwrite & ~trap_c;
                n_m2r = REGAmem2reg;
`ifdef MISALIGN_TRAP_EN
                n_mis = trap_c;
`endif
            end else if (state == DONE && !kill) begin
                n_rd  = lat_rd;
                n_res = lat_load ? hold : lat_addr;
                n_rw  = lat_rw;
                n_m2r = lat_m2r;
            end
        end
    end

    // Control FSM, bus registers and Mem/WB registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            kill         <= 1'b0;
            hold         <= '0;
            lat_addr     <= '0;
            lat_ll       <= '0;
            lat_rd       <= '0;
            lat_rw       <= 1'b0;
            lat_m2r      <= '0;
            lat_load     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            REGMrd       <= '0;
            REGMresult   <= '0;
            REGMregwrite <= 1'b0;
            REGMmem2reg  <= '0;
`ifdef MISALIGN_TRAP_EN
            REGMmisalign <= 1'b0;
`endif
        end else begin
            REGMrd       <= n_rd;
            REGMresult   <= n_res;
            REGMregwrite <= n_rw;
            REGMmem2reg  <= n_m2r;
`ifdef MISALIGN_TRAP_EN
            REGMmisalign <= n_mis;
`endif
            case (state)
                IDLE: begin
                    if (start_c) begin
                        lat_addr   <= REGAaluresult;
                        lat_ll     <= REGAllcntl;
                        lat_rd     <= REGArd;
                        lat_rw     <= REGAregwrite;
                        lat_m2r    <= REGAmem2reg;
                        lat_load   <= REGAiord & ~REGAwenable;
                        dmem_we    <= REGAwenable;
                        dmem_addr  <= {REGAaluresult[WIDTH-1:2], 2'b00};
                        dmem_wdata <= wdata_c;
                        dmem_be    <= be_c;
                        dmem_req   <= 1'b1;
                        kill       <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A flush here cannot abort the bus; it kills the writeback.
                    if (MemREGclear) kill <= 1'b1;
                    if (dmem_ack) begin
                        hold     <= load_fmt;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [1:0]  m2r;
        logic [2:0]  ll;
        logic [2:0]  sl;
        logic        rw;
        logic        iord;
        logic        wen;
        logic [31:0] rdata;
        int          delay;
        int          clr_k;   // -1 never, -2 random, else flush at that cycle index
    } op_t;

    typedef struct packed {
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        rw;
        logic [1:0]  m2r;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [3:0]  delay;
    } bus_t;

    logic        clk;
    logic        reset;
    logic        MemREGclear;
    logic [4:0]  REGArd;
    logic [31:0] REGAaluresult;
    logic [31:0] REGAreg2data;
    logic [1:0]  REGAmem2reg;
    logic [2:0]  REGAllcntl;
    logic [2:0]  REGAslcntl;
    logic        REGAregwrite;
    logic        REGAiord;
    logic        REGAwenable;
    logic        MemREGstall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  REGMrd;
    logic [31:0] REGMresult;
    logic        REGMregwrite;
    logic [1:0]  REGMmem2reg;
    logic        mis_w;
`ifdef MISALIGN_TRAP_EN
    logic        REGMmisalign;
    assign mis_w = REGMmisalign;
`else
    assign mis_w = 1'b0;
`endif

    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic resp_en = 1'b0;
    wb_t  exp_q[$];
    bus_t bus_q[$];

    mem_stage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .MemREGclear  (MemREGclear),
        .REGArd       (REGArd),
        .REGAaluresult(REGAaluresult),
        .REGAreg2data (REGAreg2data),
        .REGAmem2reg  (REGAmem2reg),
        .REGAllcntl   (REGAllcntl),
        .REGAslcntl   (REGAslcntl),
        .REGAregwrite (REGAregwrite),
        .REGAiord     (REGAiord),
        .REGAwenable  (REGAwenable),
        .MemREGstall  (MemREGstall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
        .REGMmisalign (REGMmisalign),
`endif
        .REGMrd       (REGMrd),
        .REGMresult   (REGMresult),
        .REGMregwrite (REGMregwrite),
        .REGMmem2reg  (REGMmem2reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic store, input logic [2:0] code);
        if (store) return (code == 3'd0) ? 1 : (code == 3'd1) ? 2 : 4;
        case (code)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic is_trap(input op_t o);
`ifdef MISALIGN_TRAP_EN
        int off = int'(o.alu[1:0]);
        int sz  = op_size(o.wen, o.wen ? o.sl : o.ll);
        return (o.iord || o.wen) && ((off % sz) != 0);
`else
        return 1'b0 & o.wen;
`endif
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] ll, input logic [31:0] addr,
                                             input logic [31:0] data);
        int off = int'(addr[1:0]);
        int sz  = op_size(1'b0, ll);
        logic [31:0] v;
        if (sz == 1) begin
            v = (data >> (8 * off)) & 32'hFF;
            if (ll == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (data >> (16 * (off / 2))) & 32'hFFFF;
            if (ll == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = data;
        end
        return v;
    endfunction

    function automatic wb_t model_wb(input op_t o);
        wb_t e;
        e     = '0;
        e.rd  = o.rd;
        e.m2r = o.m2r;
        if (is_trap(o)) begin
            e.mis = 1'b1;
            e.res = o.alu;
        end else begin
            e.rw  = o.rw;
            e.res = (o.iord && !o.wen) ? load_val(o.ll, o.alu, o.rdata) : o.alu;
        end
        return e;
    endfunction

    function automatic bus_t model_bus(input op_t o);
        bus_t b;
        int   off = int'(o.alu[1:0]);
        int   sz  = op_size(1'b1, o.sl);
        b.addr  = o.alu & 32'hFFFF_FFFC;
        b.we    = o.wen;
        b.rdata = o.rdata;
        b.delay = 4'(o.delay);
        b.wdata = o.rs2;
        b.be    = 4'hF;
        if (o.wen) begin
            if (sz == 1) begin
                b.wdata = (o.rs2 & 32'hFF) * 32'h0101_0101;
                b.be    = 4'(1 << off);
            end else if (sz == 2) begin
                b.wdata = (o.rs2 & 32'hFFFF) * 32'h0001_0001;
                b.be    = 4'(3 << (2 * (off / 2)));
            end
        end
        return b;
    endfunction

    function automatic op_t mk(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [1:0] m2r, input logic [2:0] ll, input logic [2:0] sl,
                               input logic rw, input logic iord, input logic wen,
                               input logic [31:0] rdata, input int delay, input int clr_k);
        op_t o;
        o.rd = rd; o.alu = alu; o.rs2 = rs2; o.m2r = m2r; o.ll = ll; o.sl = sl;
        o.rw = rw; o.iord = iord; o.wen = wen; o.rdata = rdata; o.delay = delay; o.clr_k = clr_k;
        return o;
    endfunction

    task automatic drive_nop();
        REGArd = '0; REGAaluresult = '0; REGAreg2data = '0; REGAmem2reg = '0;
        REGAllcntl = '0; REGAslcntl = '0; REGAregwrite = 1'b0; REGAiord = 1'b0;
        REGAwenable = 1'b0; MemREGclear = 1'b0;
    endtask

    // Present one op, hold it while stalled, push its expected writeback.
    task automatic issue_op(input op_t o);
        int   k = 0;
        int   exp_k;
        logic st;
        logic killed = 1'b0;
        logic bus_op;
        REGArd = o.rd; REGAaluresult = o.alu; REGAreg2data = o.rs2; REGAmem2reg = o.m2r;
        REGAllcntl = o.ll; REGAslcntl = o.sl; REGAregwrite = o.rw;
        REGAiord = o.iord; REGAwenable = o.wen;
        bus_op = (o.iord || o.wen) && !is_trap(o);
        if (bus_op) bus_q.push_back(model_bus(o));
        exp_k = bus_op ? o.delay + 2 : 0;
        forever begin
            MemREGclear = (o.clr_k == k) || (o.clr_k == -2 && $urandom_range(0, 9) == 0);
            @(negedge clk);
            st = MemREGstall;
            if (MemREGclear && (k > 0 || !st)) killed = 1'b1;
            if (!st) break;
            if (k >= 20) begin
                tests++; fails++;
                $display("FAIL accept_timeout got=stalled expected=accept within 20 cycles");
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
            @(posedge clk); #1;
            k++;
        end
        check("accept_cycle", 128'(k), 128'(exp_k));
        exp_q.push_back(killed ? wb_t'(0) : model_wb(o));
        @(posedge clk); #1;
        MemREGclear = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic prev_acc = 1'b0;
        wb_t  g;
        wb_t  e;
        forever begin
            @(negedge clk);
            if (!mon_en || !reset) begin
                prev_acc = 1'b0;
            end else begin
                g = {mis_w, REGMrd, REGMresult, REGMregwrite, REGMmem2reg};
                if (prev_acc) begin
                    if (exp_q.size() == 0) begin
                        check("wb_unexpected", 128'(g), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_record", 128'(g), 128'(e));
                    end
                end else begin
                    check("bubble_regwrite", 128'(REGMregwrite), 128'(1'b0));
                end
                prev_acc = !MemREGstall;
            end
        end
    end

    // ---------------- bus responder ----------------
    initial begin
        bus_t t;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (resp_en && reset) begin
                if (dmem_req) begin
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", 128'(dmem_req), 128'(1'b0));
                    end else begin
                        t = bus_q.pop_front();
                        check("bus_hdr", 128'({dmem_addr, dmem_we, dmem_be}), 128'({t.addr, t.we, t.be}));
                        if (t.we) check("bus_wdata", 128'(dmem_wdata), 128'(t.wdata));
                        for (int i = 0; i < int'(t.delay); i++) @(negedge clk);
                        check("req_held", 128'({dmem_req, dmem_addr}), 128'({1'b1, t.addr}));
                        dmem_ack   = 1'b1;
                        dmem_rdata = t.rdata;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    // stray ack outside a transaction must be ignored
                    dmem_ack   = 1'b1;
                    dmem_rdata = $urandom;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        op_t dir[$];
        op_t o;
        int  kind;
        reset = 1'b0;
        drive_nop();
        #1;
        check("reset_outputs",
              128'({MemREGstall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                    REGMrd, REGMresult, REGMregwrite, REGMmem2reg, mis_w}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        mon_en  = 1'b1;
        resp_en = 1'b1;

        dir.push_back(mk(5'd5, 32'h0000_0123, 32'h0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0, 0, -1));
        dir.push_back(mk(5'd7, 32'h0000_1003, 32'h0, 2'd1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 32'h80FF_1234, 1, -1));
        dir.push_back(mk(5'd8, 32'h0000_1003, 32'h0, 2'd1, 3'b100, 3'd0, 1'b1, 1'b1, 1'b0, 32'h80FF_1234, 1, -1));
        dir.push_back(mk(5'd0, 32'h0000_2002, 32'hDEAD_BEEF, 2'd0, 3'd0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0, 0, -1));
        dir.push_back(mk(5'd9, 32'h0000_4000, 32'h0, 2'd1, 3'b010, 3'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 2, 1));
        dir.push_back(mk(5'd10, 32'h0000_0ABC, 32'h0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0, 0, -1));
        dir.push_back(mk(5'd11, 32'h0000_3002, 32'h0, 2'd1, 3'b010, 3'd0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 0, -1));
        dir.push_back(mk(5'd12, 32'h0000_5001, 32'h0000_00A5, 2'd0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 0, -1));
        foreach (dir[i]) issue_op(dir[i]);

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            o = mk(5'($urandom), $urandom, $urandom, 2'($urandom), 3'($urandom),
                   3'($urandom_range(0, 2)), 1'($urandom), kind == 1 || kind == 3,
                   kind >= 2, $urandom, int'($urandom_range(0, 3)), -2);
            issue_op(o);
        end

        drive_nop();
        @(negedge clk);
        @(posedge clk); #1;
        mon_en = 1'b0;
        check("queues_drained", 128'({exp_q.size(), bus_q.size()}), 128'(0));

        // asynchronous reset in the middle of a bus transaction
        resp_en = 1'b0;
        @(posedge clk); #1;
        REGArd = 5'd3; REGAaluresult = 32'h40; REGAregwrite = 1'b1; REGAiord = 1'b1;
        REGAllcntl = 3'b010;
        for (int i = 0; i < 5 && !dmem_req; i++) @(negedge clk);
        check("rst_req_before", 128'(dmem_req), 128'(1'b1));
        #2 reset = 1'b0;
        #1;
        check("rst_req", 128'(dmem_req), 128'(1'b0));
        check("rst_stall", 128'(MemREGstall), 128'(1'b0));
        check("rst_regm", 128'({REGMrd, REGMresult, REGMregwrite, REGMmem2reg, mis_w}), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_idle_stall", 128'(MemREGstall), 128'(1'b1));
        check("rst_idle_req", 128'(dmem_req), 128'(1'b0));
        drive_nop();
        @(posedge clk); #1;
        check("post_rst_idle", 128'({dmem_req, MemREGstall}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage (5th of 6) directly downstream of the Ex stage; consumes the Ex pipeline registers (ALU result, rs2 data, load/store controls).
- Issues one data-memory transaction per load/store over a req/ack bus, formats store data/byte-enables and load data, stalls upstream until done.
- Registers results into the Mem/WB pipeline registers.

Parameters:
WIDTH, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MemREGclear  in  1  sync flush of Mem/WB registers (bubble)
REGArd  in  5  dest reg from Ex
REGAaluresult  in  32  ALU result / memory address
REGAreg2data  in  32  store data (rs2)
REGAmem2reg  in  2  WB select: 01=load data, other=ALU result
REGAllcntl  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
REGAslcntl  in  3  store type: 000 SB, 001 SH, 010 SW
REGAregwrite  in  1  reg write enable
REGAiord  in  1  1 = load
REGAwenable  in  1  1 = store
MemREGstall  out  1  hold Ex stage and upstream
dmem_req  out  1  bus request (registered)
dmem_we  out  1  1=write
dmem_addr  out  32  word address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  transaction complete (1 cycle pulse)
dmem_rdata  in  32  read data, valid with ack
REGMrd  out  5  Mem/WB dest reg
REGMresult  out  32  WB value (load data or ALU result)
REGMregwrite  out  1  Mem/WB write enable
REGMmem2reg  out  2  passthrough

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, kill flag 0, hold register 0.
- memop = REGAiord | REGAwenable (both set: treated as store).
- FSM IDLE/BUSY/DONE:
  - IDLE, no memop: MemREGstall=0; Mem/WB registers load from inputs (result=REGAaluresult). Latency 1.
  - IDLE, memop: MemREGstall=1; latch addr, dmem_we, wdata, be, llcntl, rd, regwrite, mem2reg; next BUSY with dmem_req=1. Mem/WB registers load a bubble (regwrite=0).
  - BUSY: MemREGstall=1, dmem_req held 1, bus outputs stable. On dmem_ack: capture formatted load data into hold register, dmem_req=0 next cycle, go DONE.
  - DONE: MemREGstall=0 (upstream advances); Mem/WB registers load latched rd/regwrite/mem2reg and result (hold data for load, latched addr for store); go IDLE.
- Minimum load latency: op present cycle 0, req cycles 1..n, ack cycle n, DONE n+1, REGM valid from n+2.
- Store format: SB wdata={4{rs2[7:0]}}, be=0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=0011<<{addr[1],0}; SW wdata=rs2, be=1111. Loads: be=1111, we=0.
- Load format: byte = rdata lane addr[1:0]; half = lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Undefined llcntl codes -> LW.
- Without optional feature: misaligned halfword/word addresses have low bits ignored (lane by addr[1] / full word).
- MemREGclear: IDLE/DONE -> Mem/WB registers loaded with zeros this edge, DONE returns to IDLE without writeback. BUSY -> bus transaction continues to ack (never aborted); kill flag set; DONE then writes a bubble. Clear has priority over load of Mem/WB regs.
- Ack in IDLE/DONE ignored. Reset mid-BUSY drops req immediately (async).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output REGMmisalign (1 bit, reset 0). LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0: no bus request, no stall, Mem/WB gets REGMmisalign=1, regwrite=0, result=faulting address; latency 1.
- Undefined: port absent; misaligned accesses handled as in Behaviour.

Test Plan:
- ADD result 0x00000123, rd=5, regwrite=1, no memop -> next cycle REGMresult=0x123, REGMrd=5, no stall, dmem_req=0.
- LB addr 0x1003, rdata=0x80FF_1234, ack after 2 BUSY cycles -> dmem_addr=0x1000, be=1111, stall 3 cycles, REGMresult=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x2002, rs2=0xDEADBEEF -> dmem_we=1, wdata=0xBEEFBEEF, be=1100, REGMregwrite=0.
- LW in flight, MemREGclear asserted in BUSY -> req held until ack, then REGMregwrite=0, REGMresult=0; next op proceeds normally.
- Async reset mid-BUSY -> dmem_req, MemREGstall, all REGM* 0 immediately; state IDLE.
- MISALIGN_TRAP_EN: LW addr 0x3002 -> no dmem_req, REGMmisalign=1, REGMresult=0x3002, REGMregwrite=0; without macro -> dmem_addr=0x3000, normal load.
